// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by bus stores, programmable bit period,
// status/divisor readback on a combinational read bus qualified by sel.
module uart_tx_mmio #(
  parameter logic [15:0] BASE    = 16'hFF00,
  parameter int          DEPTH   = 8,
  parameter logic [15:0] DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic        ren,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [15:0]   r_div;
  logic [15:0]   r_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;
  logic          r_tx;
  logic          r_irq;
  logic          r_ovf;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_in_win;
  logic [1:0]    w_off;
  logic          w_wr_data;
  logic          w_wr_stat;
  logic          w_wr_div;
  logic          w_empty;
  logic          w_full;
  logic          w_busy;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [7:0]    w_head;
  logic [15:0]   w_div_eff;
  logic [15:0]   w_reload;
  logic          w_cnt_zero;
  logic [3:0]    w_count4;
  logic [15:0]   w_status;
  logic          w_unused_addr0;

  // Window is BASE..BASE+5; the fourth word slot (BASE+6) is outside it.
  assign w_in_win  = (addr[15:3] == BASE[15:3]) && (addr[2:1] != 2'b11);
  assign w_off     = addr[2:1];
  assign sel       = w_in_win;
  assign w_unused_addr0 = addr[0];

  assign w_wr_data = wen && w_in_win && (w_off == 2'b00);
  assign w_wr_stat = wen && w_in_win && (w_off == 2'b01);
  assign w_wr_div  = wen && w_in_win && (w_off == 2'b10);

  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_full    = (r_count == DEPTH_C);
  assign w_busy    = (r_state != S_IDLE);
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  // A full FIFO still accepts a byte when the framer pops in the same cycle.
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_drop    = w_wr_data && !w_push;
  assign w_head    = r_mem[r_rptr];

  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_reload   = w_div_eff - 16'd1;
  assign w_cnt_zero = (r_cnt == 16'd0);

  assign w_count4 = 4'(r_count);
  assign w_status = {8'h00, w_count4, r_ovf, w_busy, w_empty, w_full};

  // Read mux: driven only for a read strobe inside the window
  always_comb begin
    dout = 16'h0000;
    if (ren && w_in_win) begin
      case (w_off)
        2'b00:   dout = 16'h0000;
        2'b01:   dout = w_status;
        2'b10:   dout = r_div;
        default: dout = 16'h0000;
      endcase
    end else begin
      dout = 16'h0000;
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + P_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Control registers: sticky overflow, divisor, idle interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_div <= DIV_RST;
      r_irq <= 1'b1;
    end else begin
      r_ovf <= (r_ovf && !w_wr_stat) || w_drop;
      if (w_wr_div) begin
        r_div <= din;
      end
      r_irq <= (r_state == S_IDLE) && w_empty;
    end
  end

  // Framing FSM: start bit, eight data bits LSB-first, stop bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_shift <= 8'h00;
      r_idx   <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_cnt   <= w_reload;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_cnt_zero) begin
            r_tx    <= r_shift[0];
            r_idx   <= 3'd0;
            r_cnt   <= w_reload;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            r_cnt <= w_reload;
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-map vector table plus hand-timed frame sequences.
module tb_uart_tx_mmio;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        wen  = 1'b0;
  logic        ren  = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] din  = 16'h0000;
  logic [15:0] dout;
  logic        sel;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio dut (
    .clk (clk),
    .rst (rst),
    .wen (wen),
    .ren (ren),
    .addr(addr),
    .din (din),
    .dout(dout),
    .sel (sel),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic        exp_sel;
    logic [15:0] exp_dout;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic exp_sel,
                    input logic [15:0] exp_dout);
    addr = a;
    ren  = 1'b1;
    #1;
    chk({nm, " sel"}, {15'd0, sel}, {15'd0, exp_sel});
    chk({nm, " dout"}, dout, exp_dout);
    ren = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    din  = d;
    wen  = 1'b1;
    @(negedge clk);
    wen  = 1'b0;
  endtask

  initial begin
    logic [9:0] fr;
    logic       exp_q[$];
    int         dur [10];
    logic       e;

    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF02, 1'b1, 16'h0002};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF04, 1'b1, 16'h01B2};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF00, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 16'hFF04, 16'h1234, 16'hFF04, 1'b1, 16'h1234};
    vecs[4]  = '{1'b1, 16'hFF06, 16'hBEEF, 16'hFF06, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF04, 1'b1, 16'h1234};
    vecs[6]  = '{1'b1, 16'hFE00, 16'h0055, 16'hFF03, 1'b1, 16'h0002};
    vecs[7]  = '{1'b1, 16'hFF05, 16'h00FF, 16'hFF04, 1'b1, 16'h00FF};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'hFF08, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 16'hFEFE, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 16'hFF02, 16'h0000, 16'hFF02, 1'b1, 16'h0002};

    // Reset state while rst is held low
    repeat (2) @(negedge clk);
    chk("reset tx", {15'd0, tx}, 16'h0001);
    chk("reset irq", {15'd0, irq}, 16'h0001);
    rd("reset status", 16'hFF02, 1'b1, 16'h0002);
    rd("reset div", 16'hFF04, 1'b1, 16'h01B2);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].waddr, vecs[i].wdata);
      end
      rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_sel, vecs[i].exp_dout);
      @(negedge clk);
    end

    // Read and write of DIV in the same cycle: old value before the edge
    addr = 16'hFF04; din = 16'h0042; wen = 1'b1; ren = 1'b1;
    #1;
    chk("rw_same old", dout, 16'h00FF);
    @(negedge clk);
    wen = 1'b0;
    #1;
    chk("rw_same new", dout, 16'h0042);
    ren = 1'b0;
    @(negedge clk);

    // Single byte A5 at DIV=4
    wr(16'hFF04, 16'd4);
    wr(16'hFF00, 16'h00A5);
    chk("single tx before start", {15'd0, tx}, 16'h0001);
    chk("single irq at push", {15'd0, irq}, 16'h0001);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("single tx k%0d", k), {15'd0, tx}, {15'd0, fr[k / 4]});
      if (k == 0) chk("single irq falls", {15'd0, irq}, 16'h0000);
    end
    @(negedge clk);
    chk("single tx after stop", {15'd0, tx}, 16'h0001);
    chk("single irq still low", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    chk("single irq rises", {15'd0, irq}, 16'h0001);

    // Back-to-back 00 then FF at DIV=2
    wr(16'hFF04, 16'd2);
    wr(16'hFF00, 16'h0000);
    wr(16'hFF00, 16'h00FF);
    for (int k = 0; k < 41; k++) begin
      e = (k < 18) ? 1'b0 : (k < 21) ? 1'b1 : (k < 23) ? 1'b0 : 1'b1;
      chk($sformatf("b2b tx k%0d", k), {15'd0, tx}, {15'd0, e});
      @(negedge clk);
    end
    @(negedge clk);
    chk("b2b irq", {15'd0, irq}, 16'h0001);
    rd("b2b status", 16'hFF02, 1'b1, 16'h0002);

    // DIV=0 behaves as 1: ten-clock frame
    wr(16'hFF04, 16'd0);
    rd("div0 readback", 16'hFF04, 1'b1, 16'h0000);
    wr(16'hFF00, 16'h0096);
    fr = {1'b1, 8'h96, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("div0 tx k%0d", k), {15'd0, tx}, {15'd0, fr[k]});
    end
    @(negedge clk);
    rd("div0 idle status", 16'hFF02, 1'b1, 16'h0002);

    // DIV 3 -> 5 written during data bit 2
    wr(16'hFF04, 16'd3);
    wr(16'hFF00, 16'h0055);
    fr  = {1'b1, 8'h55, 1'b0};
    dur = '{3, 3, 3, 3, 5, 5, 5, 5, 5, 5};
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < dur[b]; j++) exp_q.push_back(fr[b]);
    end
    @(negedge clk);
    for (int k = 0; k < 42; k++) begin
      chk($sformatf("divchg tx k%0d", k), {15'd0, tx}, {15'd0, exp_q[k]});
      if (k == 9) wr(16'hFF04, 16'd5);
      else @(negedge clk);
    end
    rd("divchg idle status", 16'hFF02, 1'b1, 16'h0002);
    rd("divchg div", 16'hFF04, 1'b1, 16'h0005);

    // Fill and overflow at DIV=FFFF
    wr(16'hFF04, 16'hFFFF);
    for (int i = 0; i < 9; i++) wr(16'hFF00, 16'(i + 16));
    rd("fill status", 16'hFF02, 1'b1, 16'h0085);
    chk("fill irq", {15'd0, irq}, 16'h0000);
    wr(16'hFF00, 16'h0099);
    rd("ovf status", 16'hFF02, 1'b1, 16'h008D);
    wr(16'hFF02, 16'h0000);
    rd("ovf cleared", 16'hFF02, 1'b1, 16'h0085);
    rst = 1'b0;
    #1;
    chk("fill reset tx", {15'd0, tx}, 16'h0001);
    rd("fill reset status", 16'hFF02, 1'b1, 16'h0002);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset during data bit 4 of 0x0F at DIV=4, second byte queued
    wr(16'hFF04, 16'd4);
    wr(16'hFF00, 16'h000F);
    wr(16'hFF00, 16'h00F0);
    repeat (19) @(negedge clk);
    chk("midrst bit3", {15'd0, tx}, 16'h0001);
    repeat (2) @(negedge clk);
    chk("midrst bit4", {15'd0, tx}, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst tx async", {15'd0, tx}, 16'h0001);
    chk("midrst irq", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst tx idle", {15'd0, tx}, 16'h0001);
    rd("midrst status", 16'hFF02, 1'b1, 16'h0002);
    rd("midrst div", 16'hFF04, 1'b1, 16'h01B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
